pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Power-up and lock-recovery sequencer for the board PLL chain. Runs on the 50 MHz board clock. Holds the PLLs in reset for a fixed power-up delay, releases them, and qualifies both lock indicators over a stability window. If lock is lost or never arrives, it re-pulses the PLL reset, up to a bounded retry count. Its `pll_areset` drives the PLL `areset` pins, and `pll_ready` gates the downstream system-reset generation.

## Interface
- `INIT_DELAY`, default 24'd2500000: power-up cycles with PLL held in reset (50 ms at 50 MHz).
- `RST_PULSE`, default 16'd50: `pll_areset` width on each retry, in cycles.
- `LOCK_TIMEOUT`, default 24'd500000: cycles allowed for both locks to assert after reset release.
- `STABLE_CYCLES`, default 16'd1024: consecutive cycles both locks must stay high before ready.
- `MAX_RETRY`, default 4'd3: retries allowed before declaring fault.
- `clk`, in, 1: 50 MHz board clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `locked0_in`, in, 1: lock from first PLL; asynchronous to `clk`.
- `locked1_in`, in, 1: lock from second (cascaded) PLL; asynchronous to `clk`.
- `pll_areset`, out, 1: PLL reset, active high.
- `pll_ready`, out, 1: high only in RUN.
- `fault`, out, 1: sticky; set on entry to FAULT.
- `lock_lost`, out, 1: one-cycle pulse when a lock drops while in RUN.
- `retry_cnt`, out, 4: retries issued since reset or since the last RUN entry.
- `state`, out, 3: current FSM state, for debug.

## Operation
- Each lock input passes through a 2-FF synchronizer. `lk = sync0 & sync1`.
- One shared 24-bit counter `cnt`. It is cleared on every state change and otherwise increments.
- FSM encoding: INIT=0, PRST=1, WAIT=2, STAB=3, RUN=4, FAULT=5. Codes 6 and 7 go to INIT.
- INIT: `pll_areset`=1. When `cnt==INIT_DELAY-1`, go to WAIT.
- PRST: `pll_areset`=1. When `cnt==RST_PULSE-1`, go to WAIT.
- WAIT: `pll_areset`=0.
  - If `lk` is high, go to STAB.
  - Otherwise, when `cnt==LOCK_TIMEOUT-1`, take the retry path.
  - Lock takes priority over timeout when both occur in the same cycle.
- STAB:
  - If `lk` is low, take the retry path.
  - Otherwise, when `cnt==STABLE_CYCLES-1`, go to RUN and clear `retry_cnt`.
- RUN: `pll_ready`=1. If `lk` is low, assert `lock_lost` for one cycle and take the retry path.
- Retry path:
  - If `retry_cnt==MAX_RETRY`, go to FAULT.
  - Otherwise increment `retry_cnt` and go to PRST.
- FAULT: `pll_areset`=1, `fault`=1, `pll_ready`=0. FAULT is terminal; only `rst_n` exits it.
- Lock inputs are ignored in INIT, PRST and FAULT.
- `retry_cnt` never exceeds `MAX_RETRY`; no wrap-around.

## Timing
- Reset values: `state`=INIT, `pll_areset`=1, `pll_ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0, `cnt`=0, synchronizer flops=0.
- All outputs are registered and update on the same edge as the state transition.
- No combinational path from any input to any output.
- Synchronizer latency: 2 cycles. A lock drop reaches the FSM on the 3rd edge after it occurs.
- Edges are counted from the first rising edge after `rst_n` deasserts:
  - `pll_areset` falls after edge `INIT_DELAY`.
  - `pll_ready` rises no earlier than edge `INIT_DELAY+STABLE_CYCLES+1`.
- Assertion of `rst_n` mid-sequence forces all reset values immediately, independent of the clock. The sequence then restarts from INIT.
- On lock loss in RUN, `pll_ready` falls and `pll_areset` rises on the same edge that raises `lock_lost`.

## Test plan
All scenarios use `INIT_DELAY`=8, `RST_PULSE`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=6, `MAX_RETRY`=2.
- Both locks held high from reset -> `pll_areset` falls after edge 8; state WAIT at edge 8, STAB at edge 9, RUN at edge 15; `pll_ready` high after edge 15; `retry_cnt`=0.
- Both locks held low -> retries issued at edges 28 and 52 (`retry_cnt`=1 then 2); `pll_areset` high for 4 cycles after each; FAULT at edge 76 with `fault`=1 and `pll_areset`=1 thereafter.
- Reach RUN, then drop `locked1_in` for 1 cycle -> `lock_lost` is one pulse 3 edges later; state PRST with `retry_cnt`=1; after the lock returns, `pll_ready` reasserts 4+1+6 cycles after the drop is seen, and `retry_cnt` returns to 0.
- `locked0_in` glitches low for 1 cycle mid-STAB -> state PRST with `retry_cnt`=1; `pll_ready` never asserts during the glitch.
- Lock arrives on the cycle where `cnt==19` in WAIT -> state STAB, no retry.
- `rst_n` pulsed low while in RUN, and again while in FAULT -> outputs go to reset values immediately; the INIT timing of scenario 1 repeats exactly.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL power-up and lock-recovery sequencer: holds the PLL chain in reset, qualifies
// both lock indicators over a stability window and re-pulses reset on loss with bounded retries.
module pll_reset_sequencer #(
  parameter logic [23:0] INIT_DELAY    = 24'd2500000,
  parameter logic [15:0] RST_PULSE     = 16'd50,
  parameter logic [23:0] LOCK_TIMEOUT  = 24'd500000,
  parameter logic [15:0] STABLE_CYCLES = 16'd1024,
  parameter logic [3:0]  MAX_RETRY     = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked0_in,
  input  logic       locked1_in,
  output logic       pll_areset,
  output logic       pll_ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_PRST  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STAB  = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  localparam logic [23:0] INIT_LAST    = INIT_DELAY - 24'd1;
  localparam logic [23:0] PULSE_LAST   = {8'd0, RST_PULSE - 16'd1};
  localparam logic [23:0] TIMEOUT_LAST = LOCK_TIMEOUT - 24'd1;
  localparam logic [23:0] STABLE_LAST  = {8'd0, STABLE_CYCLES - 16'd1};

  state_e      state_q, state_d, fsm_next;
  logic [23:0] cnt_q;
  logic [1:0]  sync0_q, sync1_q;
  logic [3:0]  retry_q, retry_d;
  logic        areset_q, ready_q, fault_q, lost_q;
  logic        lk, retry_path, clr_retry, lost_d;

  assign lk = sync0_q[1] & sync1_q[1];

  // Per-state transition decision, before the retry path is resolved
  always_comb begin
    fsm_next   = state_q;
    retry_path = 1'b0;
    clr_retry  = 1'b0;
    lost_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) fsm_next = ST_WAIT;
        else                    fsm_next = ST_INIT;
      end
      ST_PRST: begin
        if (cnt_q == PULSE_LAST) fsm_next = ST_WAIT;
        else                     fsm_next = ST_PRST;
      end
      ST_WAIT: begin
        // lock wins over a timeout landing on the same cycle
        if (lk)                          fsm_next = ST_STAB;
        else if (cnt_q == TIMEOUT_LAST)  retry_path = 1'b1;
        else                             fsm_next = ST_WAIT;
      end
      ST_STAB: begin
        if (!lk) begin
          retry_path = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          fsm_next  = ST_RUN;
          clr_retry = 1'b1;
        end else begin
          fsm_next = ST_STAB;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          lost_d     = 1'b1;
          retry_path = 1'b1;
        end else begin
          fsm_next = ST_RUN;
        end
      end
      ST_FAULT: fsm_next = ST_FAULT;
      default:  fsm_next = ST_INIT;
    endcase
  end

  // Retry path: re-pulse the PLL reset or give up once the budget is spent
  always_comb begin
    state_d = fsm_next;
    retry_d = retry_q;
    if (retry_path && (retry_q >= MAX_RETRY)) begin
      state_d = ST_FAULT;
    end else if (retry_path) begin
      state_d = ST_PRST;
      retry_d = retry_q + 4'd1;
    end else if (clr_retry) begin
      retry_d = 4'd0;
    end else begin
      retry_d = retry_q;
    end
  end

  // Synchronizers, shared counter, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q  <= 2'b00;
      sync1_q  <= 2'b00;
      state_q  <= ST_INIT;
      cnt_q    <= 24'd0;
      retry_q  <= 4'd0;
      areset_q <= 1'b1;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      sync0_q  <= {sync0_q[0], locked0_in};
      sync1_q  <= {sync1_q[0], locked1_in};
      state_q  <= state_d;
      cnt_q    <= (state_d != state_q) ? 24'd0 : cnt_q + 24'd1;
      retry_q  <= retry_d;
      areset_q <= (state_d == ST_INIT) || (state_d == ST_PRST) || (state_d == ST_FAULT);
      ready_q  <= (state_d == ST_RUN);
      fault_q  <= fault_q | (state_d == ST_FAULT);
      lost_q   <= lost_d;
    end
  end

  assign pll_areset = areset_q;
  assign pll_ready  = ready_q;
  assign fault      = fault_q;
  assign lock_lost  = lost_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule
